rd_checker_multilane: RTL and testbench

- Multi-lane running-disparity checker for the 8b/10b encoder verification environment.
- Tracks running disparity (RD) independently per lane and flags disparity violations on each received codeword.
- Counts total violations in one saturating counter.
- Sits on the encoder output bus, alongside the scoreboard, and feeds error status to the checker and coverage logic.

---
 rtl/rd_checker_multilane.sv | 111 +++++++++++
 tb/tb_rd_checker_multilane.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rd_checker_multilane.sv
// Multi-lane 8b/10b running-disparity checker: per-lane RD tracking, per-word
// violation flags, and a saturating total violation counter with sticky flag.
module rd_checker_multilane #(
    parameter int   WIDTH   = 10,
    parameter int   NLANES  = 4,
    parameter int   ERRW    = 16,
    parameter logic RD_INIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [NLANES-1:0]        start_in,
    input  logic [NLANES*WIDTH-1:0]  data_in,
    input  logic                     clr_cnt,
    output logic                     valid_out,
    output logic [NLANES-1:0]        rd_out,
    output logic [NLANES-1:0]        err_out,
    output logic [ERRW-1:0]          err_cnt,
    output logic                     sticky_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int NW = $clog2(NLANES + 1);
    localparam logic [CW-1:0] HALF    = CW'(WIDTH / 2);
    localparam logic [CW-1:0] HALF_P1 = CW'(WIDTH / 2 + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(WIDTH / 2 - 1);

    logic [CW-1:0]     w_ones [NLANES];
    logic [NLANES-1:0] w_rd_cur;
    logic [NLANES-1:0] w_rd_next;
    logic [NLANES-1:0] w_viol;
    logic [NW-1:0]     w_nviol;
    logic [ERRW:0]     w_sum;
    logic [ERRW-1:0]   w_cnt_next;

    logic              r_valid;
    logic [NLANES-1:0] r_rd;
    logic [NLANES-1:0] r_err;
    logic [ERRW-1:0]   r_cnt;
    logic              r_sticky;

    always_comb begin
        for (int unsigned i = 0; i < NLANES; i++) begin
            w_ones[i] = '0;
            for (int unsigned j = 0; j < WIDTH; j++) begin
                w_ones[i] = w_ones[i] + CW'(data_in[i*WIDTH + j]);
            end
        end
    end

    // Disparity is classified by ones count against WIDTH/2: +-1 maps to d = +-2.
    always_comb begin
        w_rd_cur  = '0;
        w_rd_next = r_rd;
        w_viol    = '0;
        if (valid_in) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                w_rd_cur[i] = start_in[i] ? RD_INIT : r_rd[i];
                if (w_ones[i] == HALF) begin
                    w_rd_next[i] = w_rd_cur[i];
                end else if (w_ones[i] == HALF_P1) begin
                    w_rd_next[i] = 1'b1;
                    w_viol[i]    = w_rd_cur[i];
                end else if (w_ones[i] == HALF_M1) begin
                    w_rd_next[i] = 1'b0;
                    w_viol[i]    = ~w_rd_cur[i];
                end else begin
                    w_rd_next[i] = (w_ones[i] > HALF);
                    w_viol[i]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_nviol = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            w_nviol = w_nviol + NW'(w_viol[i]);
        end
        w_sum      = {1'b0, r_cnt} + (ERRW + 1)'(w_nviol);
        w_cnt_next = w_sum[ERRW] ? '1 : w_sum[ERRW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_rd     <= {NLANES{RD_INIT}};
            r_err    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_valid <= valid_in;
            r_rd    <= w_rd_next;
            r_err   <= w_viol;
            if (clr_cnt) begin
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_cnt <= w_cnt_next;
                if (|w_viol) r_sticky <= 1'b1;
            end
        end
    end

    assign valid_out  = r_valid;
    assign rd_out     = r_rd;
    assign err_out    = r_err;
    assign err_cnt    = r_cnt;
    assign sticky_err = r_sticky;

endmodule

// File: tb/tb_rd_checker_multilane.sv
// Table-driven bench for rd_checker_multilane with a scoreboard queue; a second
// instance with a 4-bit counter exercises saturation.
module tb_rd_checker_multilane;

    localparam int W  = 10;
    localparam int NL = 4;

    localparam logic [W-1:0] BAL = 10'b0101010101;
    localparam logic [W-1:0] P2  = 10'b0111010101;
    localparam logic [W-1:0] M2  = 10'b1000101010;
    localparam logic [W-1:0] P4  = 10'b1111111000;
    localparam logic [W-1:0] Z   = 10'b0000000000;
    localparam logic [W-1:0] ONE = 10'b1111111111;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic [NL-1:0]     start_in;
    logic [NL*W-1:0]   data_in;
    logic              clr_cnt;
    logic              valid_out, sticky_err;
    logic [NL-1:0]     rd_out, err_out;
    logic [15:0]       err_cnt;
    logic              s_valid_out, s_sticky_err;
    logic [NL-1:0]     s_rd_out, s_err_out;
    logic [3:0]        s_err_cnt;

    always #5 clk = ~clk;

    rd_checker_multilane #(.WIDTH(W), .NLANES(NL), .ERRW(16), .RD_INIT(1'b0)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .start_in(start_in),
        .data_in(data_in), .clr_cnt(clr_cnt), .valid_out(valid_out),
        .rd_out(rd_out), .err_out(err_out), .err_cnt(err_cnt), .sticky_err(sticky_err)
    );

    rd_checker_multilane #(.WIDTH(W), .NLANES(NL), .ERRW(4), .RD_INIT(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .valid_in(valid_in), .start_in(start_in),
        .data_in(data_in), .clr_cnt(clr_cnt), .valid_out(s_valid_out),
        .rd_out(s_rd_out), .err_out(s_err_out), .err_cnt(s_err_cnt), .sticky_err(s_sticky_err)
    );

    typedef struct {
        logic          v;
        logic [NL-1:0] st;
        logic [NL*W-1:0] d;
        logic          clr;
        logic [NL-1:0] e_rd;
        logic [NL-1:0] e_err;
    } vec_t;

    typedef struct {
        logic          vo;
        logic [NL-1:0] rd;
        logic [NL-1:0] err;
        logic [15:0]   cnt;
        logic [3:0]    cnt4;
        logic          sticky;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_cnt    = 0;
    int   m_cnt4   = 0;
    logic m_sticky = 1'b0;

    function automatic vec_t mk(input logic v, input logic [3:0] st,
                                input logic [W-1:0] l3, input logic [W-1:0] l2,
                                input logic [W-1:0] l1, input logic [W-1:0] l0,
                                input logic clr, input logic [3:0] erd, input logic [3:0] eerr);
        vec_t r;
        r.v = v; r.st = st; r.d = {l3, l2, l1, l0}; r.clr = clr;
        r.e_rd = erd; r.e_err = eerr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        exp_t e;
        int   n;
        valid_in = t.v;
        start_in = t.st;
        data_in  = t.d;
        clr_cnt  = t.clr;
        e.vo  = t.v;
        e.rd  = t.e_rd;
        e.err = t.v ? t.e_err : '0;
        n = $countones(e.err);
        if (t.clr) begin
            m_cnt = 0; m_cnt4 = 0; m_sticky = 1'b0;
        end else begin
            m_cnt  = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
            m_cnt4 = (m_cnt4 + n > 15) ? 15 : m_cnt4 + n;
            if (n > 0) m_sticky = 1'b1;
        end
        e.cnt    = 16'(m_cnt);
        e.cnt4   = 4'(m_cnt4);
        e.sticky = m_sticky;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("valid_out",    valid_out,    e.vo);
            chk("rd_out",       rd_out,       e.rd);
            chk("err_out",      err_out,      e.err);
            chk("err_cnt",      err_cnt,      e.cnt);
            chk("sticky_err",   sticky_err,   e.sticky);
            chk("sat_rd_out",   s_rd_out,     e.rd);
            chk("sat_err_out",  s_err_out,    e.err);
            chk("sat_err_cnt",  s_err_cnt,    e.cnt4);
            chk("sat_sticky",   s_sticky_err, e.sticky);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; valid_in = 1'b0; start_in = '0; data_in = '0; clr_cnt = 1'b0;

        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, BAL, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, P2,  0, 4'b0001, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, M2,  0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, P2,  0, 4'b0001, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, P2,  0, 4'b0001, 4'b0001));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, M2,  0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, P4,  0, 4'b0001, 4'b0001));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, Z,   0, 4'b0000, 4'b0001));
        tbl.push_back(mk(1, 4'b0000, BAL, P2,  BAL, BAL, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, BAL, P2,  BAL, BAL, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, BAL, P2,  BAL, BAL, 0, 4'b0100, 4'b0100));
        tbl.push_back(mk(0, 4'b1111, ONE, ONE, ONE, ONE, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, ONE, ONE, ONE, ONE, 0, 4'b0100, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, M2,  BAL, 0, 4'b0100, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, Z,   Z,   Z,   Z,   1, 4'b0000, 4'b1111));
        tbl.push_back(mk(1, 4'b0000, BAL, BAL, BAL, BAL, 0, 4'b0000, 4'b0000));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 4'b0000, ONE, ONE, ONE, ONE, 0, 4'b1111, 4'b1111));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid_out",  valid_out,  1'b0);
        chk("reset_rd_out",     rd_out,     4'b0000);
        chk("reset_err_out",    err_out,    4'b0000);
        chk("reset_err_cnt",    err_cnt,    16'd0);
        chk("reset_sticky_err", sticky_err, 1'b0);
        reset = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(posedge clk);
            #1;
            compare_out();
        end

        // Asynchronous reset with a word in flight and RD+ on every lane.
        valid_in = 1'b1; start_in = '0; clr_cnt = 1'b0;
        data_in  = {BAL, BAL, BAL, BAL};
        #2 reset = 1'b1;
        #1;
        chk("async_rd_out",     rd_out,     4'b0000);
        chk("async_err_out",    err_out,    4'b0000);
        chk("async_err_cnt",    err_cnt,    16'd0);
        chk("async_sat_cnt",    s_err_cnt,  4'd0);
        chk("async_sticky",     sticky_err, 1'b0);
        chk("async_valid_out",  valid_out,  1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0; valid_in = 1'b0;
        m_cnt = 0; m_cnt4 = 0; m_sticky = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_valid_out", valid_out, 1'b0);
        chk("post_reset_rd_out",    rd_out,    4'b0000);

        drive(mk(1, 4'b0000, P2, BAL, BAL, BAL, 0, 4'b1000, 4'b0000));
        @(posedge clk);
        #1;
        compare_out();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
